// File: rtl/tick_watchdog_if.sv
// Control and status bundle between a watchdog and its supervisor.
// Master drives arm/service/threshold inputs; slave returns the registered count and state.
interface tick_watchdog_if #(
    parameter int WIDTH = 8
);
    logic             en_i;
    logic             tick_i;
    logic             kick_i;
    logic             clear_i;
    logic [WIDTH-1:0] load_i;
    logic [WIDTH-1:0] warn_i;
    logic [WIDTH-1:0] q_o;
    logic [1:0]       state_o;
    logic             warn_o;
    logic             bite_o;

    modport master (
        output en_i, tick_i, kick_i, clear_i, load_i, warn_i,
        input  q_o, state_o, warn_o, bite_o
    );

    modport slave (
        input  en_i, tick_i, kick_i, clear_i, load_i, warn_i,
        output q_o, state_o, warn_o, bite_o
    );
endinterface

// File: rtl/tick_watchdog.sv
// Tick-driven watchdog: counts down timebase ticks, warns below a threshold, bites at zero.
// All outputs registered, one edge after the causing input; no backpressure, every cycle is accepted.
module tick_watchdog #(
    parameter int WIDTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    tick_watchdog_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WARN = 2'b10,
        BITE = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic [WIDTH-1:0] wn_q, wn_d;
    logic             warn_q, bite_q;
    logic [WIDTH-1:0] dec;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        ld_d    = ld_q;
        wn_d    = wn_q;
        dec     = q_q - WIDTH'(1);

        if (bus.clear_i) begin
            state_d = IDLE;
            q_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    q_d = '0;
                    // A zero timeout would bite instantly, so it never arms.
                    if (bus.en_i && (bus.load_i != '0)) begin
                        ld_d    = bus.load_i;
                        wn_d    = bus.warn_i;
                        q_d     = bus.load_i;
                        state_d = (bus.load_i <= bus.warn_i) ? WARN : RUN;
                    end
                end
                RUN, WARN: begin
                    if (!bus.en_i) begin
                        state_d = IDLE;
                        q_d     = '0;
                    end else if (bus.kick_i) begin
                        q_d     = ld_q;
                        state_d = (ld_q <= wn_q) ? WARN : RUN;
                    end else if (bus.tick_i && (q_q != '0)) begin
                        q_d = dec;
                        if (dec == '0) begin
                            state_d = BITE;
                        end else if (dec <= wn_q) begin
                            state_d = WARN;
                        end
                    end
                end
                BITE: begin
                    q_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    q_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            q_q     <= '0;
            ld_q    <= '0;
            wn_q    <= '0;
            warn_q  <= 1'b0;
            bite_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            ld_q    <= ld_d;
            wn_q    <= wn_d;
            warn_q  <= (state_d == WARN);
            bite_q  <= (state_d == BITE);
        end
    end

    assign bus.q_o     = q_q;
    assign bus.state_o = state_q;
    assign bus.warn_o  = warn_q;
    assign bus.bite_o  = bite_q;

endmodule

// File: tb/tb_tick_watchdog.sv
// Directed bench for tick_watchdog with hand-computed expected values.
module tb_tick_watchdog;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    tick_watchdog_if #(.WIDTH(WIDTH)) bus();

    tick_watchdog #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int q, input int st, input int w, input int b);
        chk({tag, ".q"},     32'(bus.q_o),     32'(q));
        chk({tag, ".state"}, 32'(bus.state_o), 32'(st));
        chk({tag, ".warn"},  32'(bus.warn_o),  32'(w));
        chk({tag, ".bite"},  32'(bus.bite_o),  32'(b));
    endtask

    initial begin
        bus.en_i    = 1'b0;
        bus.tick_i  = 1'b0;
        bus.kick_i  = 1'b0;
        bus.clear_i = 1'b0;
        bus.load_i  = '0;
        bus.warn_i  = '0;

        // Power-on reset
        step(); step();
        chk_all("por", 0, 0, 0, 0);
        rst = 1'b0;

        // Reset while running with q=7
        bus.load_i = 8'd7; bus.warn_i = 8'd2; bus.en_i = 1'b1;
        step();
        chk_all("arm7", 7, 1, 0, 0);
        rst = 1'b1;
        step(); step();
        chk_all("rst_run", 0, 0, 0, 0);
        bus.en_i = 1'b0;
        rst = 1'b0;
        step();
        chk_all("idle_after_rst", 0, 0, 0, 0);

        // Countdown 5 -> 0 with warn threshold 2; threshold inputs changed after arm
        bus.load_i = 8'd5; bus.warn_i = 8'd2; bus.en_i = 1'b1;
        step();
        chk_all("arm5", 5, 1, 0, 0);
        bus.load_i = 8'd9; bus.warn_i = 8'd8;
        bus.tick_i = 1'b1;
        step(); chk_all("cd4", 4, 1, 0, 0);
        step(); chk_all("cd3", 3, 1, 0, 0);
        step(); chk_all("cd2", 2, 2, 1, 0);
        step(); chk_all("cd1", 1, 2, 1, 0);
        step(); chk_all("cd0", 0, 3, 0, 1);
        bus.tick_i = 1'b0;
        bus.load_i = 8'd5; bus.warn_i = 8'd2;

        // Clear with en high: IDLE one cycle, then re-arm
        bus.clear_i = 1'b1;
        step(); chk_all("clr", 0, 0, 0, 0);
        bus.clear_i = 1'b0;
        step(); chk_all("rearm", 5, 1, 0, 0);
        bus.tick_i = 1'b1;
        step(); step(); step();
        chk_all("to_warn2", 2, 2, 1, 0);
        bus.tick_i = 1'b0; bus.kick_i = 1'b1;
        step(); chk_all("kick", 5, 1, 0, 0);
        bus.tick_i = 1'b1;
        step(); chk_all("kick_tick", 5, 1, 0, 0);
        bus.kick_i = 1'b0;

        // Run down to BITE and check it holds against kick/tick/en low
        repeat (5) step();
        chk_all("bite", 0, 3, 0, 1);
        bus.kick_i = 1'b1; bus.en_i = 1'b0;
        step(); chk_all("bite_hold", 0, 3, 0, 1);
        bus.kick_i = 1'b0; bus.tick_i = 1'b0;
        step(); chk_all("bite_hold2", 0, 3, 0, 1);
        bus.clear_i = 1'b1; bus.en_i = 1'b1;
        step(); chk_all("bite_clr", 0, 0, 0, 0);
        bus.clear_i = 1'b0;
        step(); chk_all("bite_rearm", 5, 1, 0, 0);

        // en low from RUN drops to IDLE
        bus.en_i = 1'b0;
        step(); chk_all("disarm", 0, 0, 0, 0);

        // Zero timeout never arms; load below warn arms straight into WARN
        bus.load_i = 8'd0; bus.en_i = 1'b1;
        step(); chk_all("load0_a", 0, 0, 0, 0);
        step(); chk_all("load0_b", 0, 0, 0, 0);
        bus.load_i = 8'd3; bus.warn_i = 8'd5;
        step(); chk_all("arm_warn", 3, 2, 1, 0);
        bus.en_i = 1'b0;
        step();

        // Full-range count without wrap; kick reloads the latched 255
        bus.load_i = 8'd255; bus.warn_i = 8'd0; bus.en_i = 1'b1;
        step(); chk_all("arm255", 255, 1, 0, 0);
        bus.tick_i = 1'b1;
        repeat (100) step();
        chk_all("mid155", 155, 1, 0, 0);
        bus.load_i = 8'd10;
        bus.kick_i = 1'b1;
        step(); chk_all("kick255", 255, 1, 0, 0);
        bus.kick_i = 1'b0;
        repeat (254) step();
        chk_all("wrap1", 1, 1, 0, 0);
        step(); chk_all("wrap0", 0, 3, 0, 1);
        step(); chk_all("nowrap", 0, 3, 0, 1);

        // Reset overrides BITE
        rst = 1'b1;
        step(); chk_all("rst_bite", 0, 0, 0, 0);
        rst = 1'b0;
        bus.tick_i = 1'b0; bus.en_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/tick_watchdog.md
TICK_WATCHDOG -- requirements
Module: tick_watchdog

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the counter and threshold width in bits.
REQ-002 Port clk_i  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_i  input  1  reset, synchronous and active-high.
REQ-004 Port en_i  input  1  arm request; high starts or keeps the watchdog running.
REQ-005 Port tick_i  input  1  timebase pulse from a timer tick_o; each cycle it is high counts as one tick.
REQ-006 Port kick_i  input  1  service strobe; reloads the counter.
REQ-007 Port clear_i  input  1  acknowledges and clears a bite; aborts any state.
REQ-008 Port load_i  input  WIDTH  timeout in ticks, sampled on arm.
REQ-009 Port warn_i  input  WIDTH  warning threshold in ticks, sampled on arm.
REQ-010 Port q_o  output  WIDTH  registered remaining tick count.
REQ-011 Port state_o  output  2  registered state encoding: IDLE=00, RUN=01, WARN=10, BITE=11.
REQ-012 Port warn_o  output  1  high exactly while the state is WARN.
REQ-013 Port bite_o  output  1  high exactly while the state is BITE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, WARN and BITE.
REQ-015 Per-cycle priority SHALL be: rst_i, then clear_i, then en_i low, then kick_i, then tick_i.
REQ-016 In IDLE with en_i=1 and load_i!=0, the block SHALL latch load_i and warn_i into internal registers (LD, WN) and set q_o=load_i.
REQ-017 On that same arm edge, the next state SHALL be WARN if load_i<=warn_i, else RUN.
REQ-018 In IDLE with load_i=0, the block SHALL remain in IDLE with q_o=0 regardless of en_i.
REQ-019 In RUN or WARN, tick_i=1 SHALL decrement q_o by 1 on the same edge; no wrap-around is permitted.
REQ-020 When a decrement yields q_o=0, the next state SHALL be BITE.
REQ-021 When a decrement yields 0<q_o<=WN, the next state SHALL be WARN; otherwise the state is unchanged.
REQ-022 In RUN or WARN, kick_i=1 SHALL set q_o=LD and the next state to RUN, or to WARN if LD<=WN.
REQ-023 When kick_i and tick_i are high in the same cycle, the kick SHALL win and no decrement occurs.
REQ-024 In RUN or WARN, en_i=0 SHALL move the block to IDLE on the next edge with q_o=0.
REQ-025 BITE SHALL hold q_o=0 and ignore tick_i, kick_i and en_i.
REQ-026 clear_i=1 in any state SHALL move the block to IDLE with q_o=0; if en_i stays high, re-arm follows on the next cycle.
REQ-027 load_i and warn_i changes after arming SHALL have no effect until the next arm from IDLE.
REQ-028 All outputs SHALL be registered, with a latency of one edge from the causing input.

Reset
REQ-029 With rst_i=1 at a clock edge, the block SHALL set state IDLE, q_o=0, warn_o=0, bite_o=0 and LD=WN=0.
REQ-030 Reset SHALL override every other input, including while in BITE or mid-count.

Verification
REQ-031 Reset scenario: assert rst_i for 2 cycles while in RUN with q_o=7 -> q_o=0, state_o=00, warn_o=0, bite_o=0.
REQ-032 Countdown scenario: load_i=5, warn_i=2, en_i=1, then 5 single-cycle ticks -> q_o steps 5,4,3 in RUN, then 2 with warn_o=1, then 1, then 0 with bite_o=1 and warn_o=0.
REQ-033 Kick scenario: in WARN with q_o=2, pulse kick_i -> q_o=5, state RUN, warn_o=0; with kick_i and tick_i together -> q_o=5, no decrement.
REQ-034 Bite hold scenario: in BITE, pulse kick_i, tick_i and drop en_i -> bite_o stays 1; then clear_i=1 with en_i=1 -> IDLE for one cycle, then RUN with q_o=LD.
REQ-035 Boundary scenario: load_i=0, en_i=1 -> stays IDLE, q_o=0; load_i=3, warn_i=5 -> arms directly into WARN with q_o=3.
REQ-036 Wrap scenario: WIDTH=8, load_i=255, warn_i=0, 255 ticks -> q_o reaches 0 and state BITE with no wrap; changing load_i mid-count leaves the kick reload value at 255.
